muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit for the RV64 pipeline's execute stage. It implements the full M extension, including the W variants: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. It computes one result bit per cycle with a start/done handshake, so the hazard unit holds the pipeline on `busy` and releases it on `done`. A flush from the pipeline, such as a trap or redirect, aborts an operation that is in flight.

## Interface
Parameters:
- `XLEN`, default 64: operand and result width. Must be 32 or 64.
- `SUPPORT_W`, default 1: enables the 32-bit W variants. When 0, `is_w` is ignored.

Ports:
- `clk`  in  1  clock; everything is sampled on the rising edge.
- `reset`  in  1  reset; synchronous and active-high.
- `valid`  in  1  request start. Sampled only in IDLE.
- `op`  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `is_w`  in  1  W variant. Applies to MUL, DIV, DIVU, REM and REMU; ignored for MULH/MULHSU/MULHU.
- `a`, `b`  in  XLEN  rs1 and rs2 operands. Captured at acceptance.
- `flush`  in  1  abort the current operation and drop any request presented in the same cycle.
- `busy`  out  1  high while an accepted operation has not yet produced `done`.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  XLEN  registered result. Holds its value until the next `done`.

## Operation
- **States:** IDLE, MUL, DIV, DONE.
- **Acceptance:** a request is accepted when `valid && !flush` in IDLE.
  - **Operand preparation:** if W, take the low 32 bits of each operand, sign- or zero-extended per op. Signed operands are converted to magnitudes. Record the result sign:
    - MUL/MULH/DIV: `a_sign ^ b_sign`.
    - MULHSU: `a_sign`.
    - REM: `a_sign`, i.e. the dividend sign.
  - **Iteration count:** N = 32 if W, else XLEN. Load counter = N-1.
- **Fast paths (DIV family only):** evaluated at acceptance; go straight to DONE.
  - Divide by zero: quotient = all ones; remainder = dividend, after W extension.
  - Signed overflow (a = most-negative, b = -1, at the effective width): quotient = a; remainder = 0.
- **MUL state:** shift-add on a 2N-bit accumulator, one multiplier bit per cycle.
- **DIV state:** restoring division. Each cycle shifts the remainder left, trial-subtracts the divisor and shifts one quotient bit in.
- **State transitions:** leave MUL or DIV for DONE when the counter reaches 0. DONE lasts exactly one cycle, then returns to IDLE.
- **Result formation (registered on the transition into DONE):**
  - Apply the recorded sign as a two's-complement negate.
  - MUL: low N bits of the product.
  - MULH*: high XLEN bits of the product.
  - DIV*: quotient. REM*: remainder.
  - W variants: low 32 bits sign-extended to XLEN.
- **Flush:** in any state, the next state is IDLE. Any pending DONE is cancelled, so `done` is not asserted. `result` is not updated.
- **Flush and valid together:** flush wins; the request is not accepted.
- **valid outside IDLE:** ignored; the pipeline keeps it asserted while stalled. `valid` in the DONE cycle is also ignored.
- **Reset:** state = IDLE, `busy` = 0, `done` = 0, `result` = 0, counter = 0. Reset mid-operation discards the operation.

## Timing
- Request accepted in cycle T.
- **Iterative path:** MUL/DIV states occupy cycles T+1 … T+N; DONE is in cycle T+N+1. So `done` = 1 and `result` is valid at T+65 for XLEN=64, and at T+33 for W ops.
- **Fast path:** DONE at T+1.
- `busy` = 1 from T+1 through the DONE cycle inclusive, and 0 in IDLE.
- `done` and `result` are registered outputs, with no combinational path from the inputs.
- Earliest next acceptance: the cycle after DONE.
- Flush in cycle F: state is IDLE and `busy` = 0 at F+1. A new request can be accepted at F+1.

## Test plan
All scenarios use XLEN=64, SUPPORT_W=1.
- **MUL signed:** MUL, a=7, b=0xFFFF_FFFF_FFFF_FFFD (-3), valid at T -> `done` only at T+65, `result`=0xFFFF_FFFF_FFFF_FFEB. `busy` high T+1..T+65.
- **MULHU:** a=b=0xFFFF_FFFF_FFFF_FFFF -> `result`=0xFFFF_FFFF_FFFF_FFFE.
- **MULHSU:** a=-1, b=2 -> `result`=0xFFFF_FFFF_FFFF_FFFF.
- **Signed divide and remainder:** DIV a=-7, b=2 -> 0xFFFF_FFFF_FFFF_FFFD (-3). Back-to-back REM with the same operands, accepted the cycle after DONE -> 0xFFFF_FFFF_FFFF_FFFF (-1), `done` 65 cycles after its acceptance.
- **Special cases:**
  - DIVU a=5, b=0 -> `done` at T+1, `result`=0xFFFF_FFFF_FFFF_FFFF.
  - REMU a=5, b=0 -> 5.
  - DIV a=0x8000_0000_0000_0000, b=-1 -> `done` at T+1, `result`=0x8000_0000_0000_0000.
  - REM with the same operands -> 0.
- **W variants and flush:**
  - DIVW a=0x1234_5678_FFFF_FFF9, b=2 -> `done` at T+33, `result`=0xFFFF_FFFF_FFFF_FFFD.
  - MULW a=0x7FFF_FFFF, b=2 -> 0xFFFF_FFFF_FFFF_FFFE.
  - Flush at T+10 during MUL -> no `done`, `busy`=0 at T+11. A new request at T+11 with valid and flush both low->high... specifically: a request presented at T+11 is accepted.
  - Flush and valid asserted in the same IDLE cycle -> not accepted.
  - Reset asserted mid-DIV -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 64
);
  logic            valid;
  logic [2:0]      op;
  logic            is_w;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  // Pipeline side: issues requests and flushes, watches busy/done.
  modport master (
    output valid, op, is_w, a, b, flush,
    input  busy, done, result
  );

  // Unit side.
  modport slave (
    input  valid, op, is_w, a, b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV64 M-extension unit: one result bit per cycle, start/done handshake.
module muldiv_unit #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned SUPPORT_W = 1
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  localparam int unsigned CW   = $clog2(XLEN);
  localparam int unsigned AW   = 2 * XLEN;
  localparam bit          W_OK = (SUPPORT_W != 0) && (XLEN == 64);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   acc_q;
  logic [XLEN-1:0] opnd_q;
  logic [2:0]      op_q;
  logic            w_q;
  logic            neg_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = v[31] ? '1 : '0;
    r[31:0] = v;
    return r;
  endfunction

  // Operand preparation at acceptance: W extension, magnitudes, sign, fast paths.
  logic            w_in, a_sgn_op, b_sgn_op, a_neg, b_neg, neg_in;
  logic            div_zero, div_ovf, fast_in;
  logic [XLEN-1:0] a_e, b_e, a_mag, b_mag, min_neg, fast_raw, fast_res, dividend;

  always_comb begin
    w_in     = W_OK && bus.is_w && !(!bus.op[2] && (bus.op[1:0] != 2'd0));
    a_sgn_op = (bus.op == 3'd0) || (bus.op == 3'd1) || (bus.op == 3'd2) ||
               (bus.op == 3'd4) || (bus.op == 3'd6);
    b_sgn_op = (bus.op == 3'd0) || (bus.op == 3'd1) ||
               (bus.op == 3'd4) || (bus.op == 3'd6);
    a_e = bus.a;
    b_e = bus.b;
    if (w_in) begin
      a_e = a_sgn_op ? sext32(bus.a[31:0]) : XLEN'(bus.a[31:0]);
      b_e = b_sgn_op ? sext32(bus.b[31:0]) : XLEN'(bus.b[31:0]);
    end
    a_neg = a_sgn_op && a_e[XLEN-1];
    b_neg = b_sgn_op && b_e[XLEN-1];
    a_mag = a_neg ? -a_e : a_e;
    b_mag = b_neg ? -b_e : b_e;
    case (bus.op)
      3'd0, 3'd1, 3'd4: neg_in = a_neg ^ b_neg;
      3'd2, 3'd6:       neg_in = a_neg;
      default:          neg_in = 1'b0;
    endcase
    min_neg  = w_in ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_e == '0);
    div_ovf  = ((bus.op == 3'd4) || (bus.op == 3'd6)) && (a_e == min_neg) && (b_e == '1);
    fast_in  = bus.op[2] && (div_zero || div_ovf);
    if (div_zero) fast_raw = bus.op[1] ? a_e : '1;
    else          fast_raw = bus.op[1] ? '0  : a_e;
    fast_res = w_in ? sext32(fast_raw[31:0]) : fast_raw;
    // Left-justify a 32-bit dividend so 32 left shifts consume all of it.
    dividend = w_in ? (a_mag << 32) : a_mag;
  end

  // One iteration of shift-add multiply and restoring divide, plus result formation.
  logic [XLEN:0]   sum, sh;
  logic [XLEN-1:0] diff, rnew, q, r, sel, res_d;
  logic            ge;
  logic [AW-1:0]   mul_nxt, div_nxt, acc_d, prod_raw, prod;

  always_comb begin
    sum      = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nxt  = {sum, acc_q[XLEN-1:1]};
    sh       = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
    ge       = (sh >= {1'b0, opnd_q});
    diff     = sh[XLEN-1:0] - opnd_q;
    rnew     = ge ? diff : sh[XLEN-1:0];
    div_nxt  = {rnew, acc_q[XLEN-2:0], ge};
    acc_d    = (state_q == S_MUL) ? mul_nxt : div_nxt;
    // After 32 of XLEN iterations the product sits 32 bits up in the accumulator.
    prod_raw = (W_OK && w_q) ? (mul_nxt >> 32) : mul_nxt;
    prod     = neg_q ? -prod_raw : prod_raw;
    q        = div_nxt[XLEN-1:0];
    r        = div_nxt[AW-1:XLEN];
    case (op_q)
      3'd0:             sel = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: sel = prod[AW-1:XLEN];
      3'd4, 3'd5:       sel = q;
      default:          sel = r;
    endcase
    if (op_q[2] && neg_q) sel = -sel;
    res_d = (W_OK && w_q) ? sext32(sel[31:0]) : sel;
  end

  // Control FSM with registered busy/done/result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      w_q      <= 1'b0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (bus.flush) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.valid) begin
            op_q   <= bus.op;
            w_q    <= w_in;
            neg_q  <= neg_in;
            busy_q <= 1'b1;
            cnt_q  <= w_in ? CW'(31) : CW'(XLEN - 1);
            if (fast_in) begin
              result_q <= fast_res;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else if (bus.op[2]) begin
              acc_q   <= {{XLEN{1'b0}}, dividend};
              opnd_q  <= b_mag;
              state_q <= S_DIV;
            end else begin
              acc_q   <= {{XLEN{1'b0}}, b_mag};
              opnd_q  <= a_mag;
              state_q <= S_MUL;
            end
          end
        end
        S_MUL, S_DIV: begin
          acc_q <= acc_d;
          if (cnt_q == '0) begin
            result_q <= res_d;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=64, W variants enabled).
module tb_muldiv_unit;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  muldiv_unit_if #(.XLEN(64)) bus ();

  muldiv_unit #(.XLEN(64), .SUPPORT_W(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for done after an acceptance cycle, checking latency, result and busy.
  task automatic wait_done(input string tag, input logic [63:0] exp, input int exp_lat, input bit hold);
    int lat;
    bit busy_ok;
    @(negedge clk);
    lat     = 1;
    busy_ok = 1'b1;
    if (!hold) bus.valid = 1'b0;
    while (!bus.done && lat < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_res"}, bus.result, exp);
    check_eq({tag, "_busy"}, 64'(busy_ok && bus.busy), 64'd1);
  endtask

  task automatic drive(input logic [2:0] op, input bit w, input logic [63:0] a, input logic [63:0] b);
    bus.valid = 1'b1;
    bus.op    = op;
    bus.is_w  = w;
    bus.a     = a;
    bus.b     = b;
  endtask

  task automatic issue(input string tag, input logic [2:0] op, input bit w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int exp_lat);
    @(negedge clk);
    drive(op, w, a, b);
    wait_done(tag, exp, exp_lat, 1'b0);
  endtask

  initial begin
    bit no_done;
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.valid = 1'b0;
    bus.flush = 1'b0;
    bus.op    = '0;
    bus.is_w  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_result", bus.result, 64'd0);
    reset = 1'b0;

    // MUL 7 * -3 with valid held through the DONE cycle.
    @(negedge clk);
    check_eq("idle_busy", 64'(bus.busy), 64'd0);
    drive(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_done("mul", 64'hFFFF_FFFF_FFFF_FFEB, 65, 1'b1);
    @(negedge clk);
    bus.valid = 1'b0;
    check_eq("valid_in_done_ignored", 64'(bus.busy), 64'd0);

    issue("mulhu",  3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFE, 65);
    issue("mulhsu", 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
          64'hFFFF_FFFF_FFFF_FFFF, 65);
    issue("div",    3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
          64'hFFFF_FFFF_FFFF_FFFD, 65);
    issue("rem_b2b", 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
          64'hFFFF_FFFF_FFFF_FFFF, 65);
    issue("divu_z", 3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    issue("remu_z", 3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    issue("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 1);
    issue("rem_ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'd0, 1);
    issue("divw",   3'd4, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2,
          64'hFFFF_FFFF_FFFF_FFFD, 33);
    issue("mulw",   3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2,
          64'hFFFF_FFFF_FFFF_FFFE, 33);

    // Flush at T+10 of a MUL, then a new request at T+11.
    @(negedge clk);
    drive(3'd0, 1'b0, 64'd3, 64'd5);
    @(negedge clk);
    bus.valid = 1'b0;
    no_done   = 1'b1;
    repeat (9) begin
      @(negedge clk);
      if (bus.done) no_done = 1'b0;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    if (bus.done) no_done = 1'b0;
    check_eq("flush_busy", 64'(bus.busy), 64'd0);
    check_eq("flush_no_done", 64'(no_done), 64'd1);
    check_eq("flush_result_held", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
    drive(3'd0, 1'b0, 64'd6, 64'd7);
    wait_done("flush_restart", 64'd42, 65, 1'b0);

    // Flush and valid in the same IDLE cycle.
    @(negedge clk);
    drive(3'd5, 1'b0, 64'd100, 64'd3);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    bus.flush = 1'b0;
    check_eq("flush_valid_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check_eq("flush_valid_busy2", 64'(bus.busy), 64'd0);
    check_eq("flush_valid_done", 64'(bus.done), 64'd0);

    // Reset in the middle of a DIV.
    @(negedge clk);
    drive(3'd4, 1'b0, 64'd100, 64'd7);
    @(negedge clk);
    bus.valid = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("middiv_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mrst_busy", 64'(bus.busy), 64'd0);
    check_eq("mrst_done", 64'(bus.done), 64'd0);
    check_eq("mrst_result", bus.result, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
